pri_encoder_rr: RTL and testbench



---
 rtl/pri_enc_pkg.sv | 22 ++
 rtl/pri_enc_search.sv | 60 ++++++
 rtl/pri_encoder_rr.sv | 98 +++++++++
 tb/tb_pri_encoder_rr.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pri_enc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pri_enc_pkg : mode encodings and index-width helper for the priority encoder
// rev 1.0
// ---------------------------------------------------------------------------
package pri_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic [0:0] {
        SEARCH_FIXED = 1'b0,
        SEARCH_RR    = 1'b1
    } search_mode_e;

    // Index width for a request vector of the given size (never below one bit).
    function automatic int calc_idx_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pri_enc_search.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pri_enc_search : combinational rotate / find-first / un-rotate search
// rev 1.0
// ---------------------------------------------------------------------------
module pri_enc_search
    import pri_enc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = calc_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    input  logic [IDX_W-1:0] start_i,
    input  search_mode_e     mode_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             none_o,
    output logic             multi_o
);

    localparam logic [IDX_W:0] c_width_ext = (IDX_W+1)'(WIDTH);

    logic [IDX_W-1:0] w_start;
    logic [WIDTH-1:0] w_rot;
    logic [IDX_W-1:0] w_rot_idx;

    // Addition modulo WIDTH; both operands are already below WIDTH.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_width_ext) begin
            s = s - c_width_ext;
        end
        return s[IDX_W-1:0];
    endfunction

    assign w_start = (mode_i == SEARCH_RR) ? start_i : '0;

    always_comb begin
        w_rot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rot[i] = vec_i[wrap_add(IDX_W'(i), w_start)];
        end
    end

    always_comb begin
        w_rot_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_idx = IDX_W'(i);
            end
        end
    end

    assign idx_o   = wrap_add(w_rot_idx, w_start);
    assign none_o  = ~|vec_i;
    assign multi_o = |(vec_i & (vec_i - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/pri_encoder_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pri_encoder_rr : registered N-to-log2(N) priority encoder, fixed or round-robin
// rev 1.0
// ---------------------------------------------------------------------------
module pri_encoder_rr
    import pri_enc_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int MODE  = MODE_FIXED,
    localparam int IDX_W = calc_idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_sel,
    output logic             req_ready,
    output logic             code_valid,
    output logic [IDX_W-1:0] code,
    output logic             none,
    output logic             multi,
    input  logic             code_ready
);

    localparam search_mode_e     c_mode = (MODE == MODE_RR) ? SEARCH_RR : SEARCH_FIXED;
    localparam logic [IDX_W-1:0] c_last = IDX_W'(WIDTH - 1);

    logic             code_valid_q, code_valid_d;
    logic [IDX_W-1:0] code_q, code_d;
    logic             none_q, none_d;
    logic             multi_q, multi_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic             w_none;
    logic             w_multi;

    // One-entry pipeline: a slot frees up in the same cycle the consumer drains it.
    assign req_ready = !code_valid_q || code_ready;
    assign w_accept  = req_valid && req_ready;

    pri_enc_search #(
        .WIDTH   (WIDTH)
    ) u_search (
        .vec_i   (req_sel),
        .start_i (ptr_q),
        .mode_i  (c_mode),
        .idx_o   (w_idx),
        .none_o  (w_none),
        .multi_o (w_multi)
    );

    always_comb begin
        code_valid_d = code_valid_q;
        code_d       = code_q;
        none_d       = none_q;
        multi_d      = multi_q;
        ptr_d        = ptr_q;

        if (w_accept) begin
            code_valid_d = 1'b1;
            code_d       = w_idx;
            none_d       = w_none;
            multi_d      = w_multi;
        end else if (code_ready) begin
            code_valid_d = 1'b0;
        end

        // Pointer moves past the winner; an empty vector leaves it where it was.
        if (w_accept && (c_mode == SEARCH_RR) && !w_none) begin
            ptr_d = (w_idx == c_last) ? '0 : w_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_valid_q <= 1'b0;
            code_q       <= '0;
            none_q       <= 1'b0;
            multi_q      <= 1'b0;
            ptr_q        <= '0;
        end else begin
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
            none_q       <= none_d;
            multi_q      <= multi_d;
            ptr_q        <= ptr_d;
        end
    end

    assign code_valid = code_valid_q;
    assign code       = code_q;
    assign none       = none_q;
    assign multi      = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_pri_encoder_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pri_encoder_rr : table-driven scoreboard bench over three encoder configurations
// rev 1.0
// ---------------------------------------------------------------------------
module tb_pri_encoder_rr;

    typedef struct {
        int         dut;
        logic [7:0] vec;
        int         code;
        int         none;
        int         multi;
        int         ptr;
    } vec_t;

    typedef struct {
        int id;
        int code;
        int none;
        int multi;
        int ptr;
    } exp_t;

    localparam int NVEC = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid  [3];
    logic       code_ready [3];
    logic       req_ready  [3];
    logic       code_valid [3];
    logic [2:0] code       [3];
    logic       none       [3];
    logic       multi      [3];
    logic [7:0] sel_fix8;
    logic [7:0] sel_rr8;
    logic [4:0] sel_rr5;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    vec_t tbl[NVEC];

    always #5 clk = ~clk;

    pri_encoder_rr #(.WIDTH(8), .MODE(0)) u_fix8 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_sel(sel_fix8),
        .req_ready(req_ready[0]), .code_valid(code_valid[0]), .code(code[0]),
        .none(none[0]), .multi(multi[0]), .code_ready(code_ready[0])
    );

    pri_encoder_rr #(.WIDTH(8), .MODE(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_sel(sel_rr8),
        .req_ready(req_ready[1]), .code_valid(code_valid[1]), .code(code[1]),
        .none(none[1]), .multi(multi[1]), .code_ready(code_ready[1])
    );

    pri_encoder_rr #(.WIDTH(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_sel(sel_rr5),
        .req_ready(req_ready[2]), .code_valid(code_valid[2]), .code(code[2]),
        .none(none[2]), .multi(multi[2]), .code_ready(code_ready[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int ptr_of(input int d);
        case (d)
            0:       return int'(u_fix8.ptr_q);
            1:       return int'(u_rr8.ptr_q);
            default: return int'(u_rr5.ptr_q);
        endcase
    endfunction

    task automatic sb_push(input int d, input exp_t e);
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int d, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '{-1, 0, 0, 0, 0};
        case (d)
            0:       if (sb0.size() > 0) e = sb0.pop_front(); else ok = 1'b0;
            1:       if (sb1.size() > 0) e = sb1.pop_front(); else ok = 1'b0;
            default: if (sb2.size() > 0) e = sb2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    task automatic drive(input int d, input logic [7:0] v);
        for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
        req_valid[d] = 1'b1;
        case (d)
            0:       sel_fix8 = v;
            1:       sel_rr8  = v;
            default: sel_rr5  = v[4:0];
        endcase
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
    endtask

    // Scoreboard: every drained result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (code_valid[d] && code_ready[d]) begin
                    exp_t e;
                    bit   ok;
                    sb_pop(d, e, ok);
                    if (!ok) begin
                        chk($sformatf("dut%0d unexpected result", d), 1, 0);
                    end else begin
                        chk($sformatf("dut%0d id%0d code", d, e.id), int'(code[d]), e.code);
                        chk($sformatf("dut%0d id%0d none", d, e.id), int'(none[d]), e.none);
                        chk($sformatf("dut%0d id%0d multi", d, e.id), int'(multi[d]), e.multi);
                        chk($sformatf("dut%0d id%0d ptr", d, e.id), ptr_of(d), e.ptr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // dut, vector, code, none, multi, ptr after accept
        tbl[0]  = '{0, 8'h01, 0, 0, 0, 0};
        tbl[1]  = '{0, 8'h02, 1, 0, 0, 0};
        tbl[2]  = '{0, 8'h04, 2, 0, 0, 0};
        tbl[3]  = '{0, 8'h08, 3, 0, 0, 0};
        tbl[4]  = '{0, 8'h10, 4, 0, 0, 0};
        tbl[5]  = '{0, 8'h20, 5, 0, 0, 0};
        tbl[6]  = '{0, 8'h40, 6, 0, 0, 0};
        tbl[7]  = '{0, 8'h80, 7, 0, 0, 0};
        tbl[8]  = '{0, 8'h24, 2, 0, 1, 0};
        tbl[9]  = '{0, 8'h00, 0, 1, 0, 0};
        tbl[10] = '{1, 8'h81, 0, 0, 1, 1};
        tbl[11] = '{1, 8'h81, 7, 0, 1, 0};
        tbl[12] = '{1, 8'h81, 0, 0, 1, 1};
        tbl[13] = '{2, 8'h10, 4, 0, 0, 0};
        tbl[14] = '{2, 8'h03, 0, 0, 1, 1};

        rst_n    = 1'b0;
        sel_fix8 = '0;
        sel_rr8  = '0;
        sel_rr5  = '0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]  = 1'b0;
            code_ready[k] = 1'b1;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d reset code_valid", d), int'(code_valid[d]), 0);
            chk($sformatf("dut%0d reset code", d), int'(code[d]), 0);
            chk($sformatf("dut%0d reset none", d), int'(none[d]), 0);
            chk($sformatf("dut%0d reset multi", d), int'(multi[d]), 0);
            chk($sformatf("dut%0d reset req_ready", d), int'(req_ready[d]), 1);
            chk($sformatf("dut%0d reset ptr", d), ptr_of(d), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].dut, tbl[i].vec);
            @(negedge clk);
            chk($sformatf("vec%0d req_ready", i), int'(req_ready[tbl[i].dut]), 1);
            if (req_ready[tbl[i].dut])
                sb_push(tbl[i].dut, '{i, tbl[i].code, tbl[i].none, tbl[i].multi, tbl[i].ptr});
            @(posedge clk);
            #1;
        end
        idle_all();
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: hold one result, offer a second request, then release for one cycle.
        code_ready[0] = 1'b0;
        drive(0, 8'h10);
        @(negedge clk);
        chk("bp first req_ready", int'(req_ready[0]), 1);
        sb_push(0, '{100, 4, 0, 0, 0});
        @(posedge clk);
        #1;
        sel_fix8 = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d req_ready", c), int'(req_ready[0]), 0);
            chk($sformatf("bp hold%0d code_valid", c), int'(code_valid[0]), 1);
            chk($sformatf("bp hold%0d code", c), int'(code[0]), 4);
            chk($sformatf("bp hold%0d none", c), int'(none[0]), 0);
            chk($sformatf("bp hold%0d multi", c), int'(multi[0]), 0);
            @(posedge clk);
            #1;
        end
        sel_fix8      = 8'h06;
        code_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp release req_ready", int'(req_ready[0]), 1);
        sb_push(0, '{101, 1, 0, 1, 0});
        @(posedge clk);
        #1;
        idle_all();
        @(negedge clk);
        chk("bp no bubble code_valid", int'(code_valid[0]), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp drained code_valid", int'(code_valid[0]), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset while a round-robin result is held.
        code_ready[1] = 1'b0;
        drive(1, 8'h04);
        @(negedge clk);
        chk("rst pre req_ready", int'(req_ready[1]), 1);
        @(posedge clk);
        #1;
        idle_all();
        @(negedge clk);
        chk("rst held code_valid", int'(code_valid[1]), 1);
        chk("rst held code", int'(code[1]), 2);
        chk("rst held ptr", ptr_of(1), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async code_valid", int'(code_valid[1]), 0);
        chk("rst async code", int'(code[1]), 0);
        chk("rst async ptr", ptr_of(1), 0);
        chk("rst async req_ready", int'(req_ready[1]), 1);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        code_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 8'h81);
        @(negedge clk);
        chk("post rst req_ready", int'(req_ready[1]), 1);
        sb_push(1, '{200, 0, 0, 1, 1});
        @(posedge clk);
        #1;
        idle_all();
        repeat (3) @(posedge clk);
        #1;

        chk("dut0 scoreboard empty", sb0.size(), 0);
        chk("dut1 scoreboard empty", sb1.size(), 0);
        chk("dut2 scoreboard empty", sb2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
